ctrl_pipe_hazard: RTL and testbench

//  Consumer side of the 9-bit decoder control word. Carries the word through ID/EX, EX/MEM and MEM/WB.

---
 rtl/ctrl_pipe_hazard.sv | 108 ++++++++++
 tb/tb_ctrl_pipe_hazard.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_hazard.sv
// Control-word pipeline for ID/EX, EX/MEM and MEM/WB of the MIPS core:
// load-use stall detection, branch flush, global hold and write-enable generation.
module ctrl_pipe_hazard #(
  parameter int CTRL_W = 9,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic              i_valid,
  input  logic [REG_W-1:0]  i_rs,
  input  logic [REG_W-1:0]  i_rt,
  input  logic              i_flush,
  input  logic              i_hold,
  output logic [3:0]        o_ex_ctrl,
  output logic [REG_W-1:0]  o_ex_rt,
  output logic [2:0]        o_mem_ctrl,
  output logic [1:0]        o_wb_ctrl,
  output logic              o_pc_write,
  output logic              o_ifid_write,
  output logic              o_ifid_flush,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  localparam int B_REGDST   = 8;
  localparam int B_MEMREAD  = 3;
  localparam int B_REGWRITE = 1;
  localparam int B_MEMTOREG = 0;

  logic [CTRL_W-1:0] idex_p0;
  logic [REG_W-1:0]  idex_rt_p0;
  logic [4:0]        exmem_p1;
  logic [1:0]        memwb_p2;
  logic [CNT_W-1:0]  stall_cnt;
  logic              haz;

  // Bubbles become all-zero; RegDst/MemtoReg are meaningless without RegWrite.
  function automatic logic [CTRL_W-1:0] mask_ctrl(input logic [CTRL_W-1:0] c,
                                                  input logic              v);
    logic [CTRL_W-1:0] m;
    m = v ? c : '0;
    if (!m[B_REGWRITE]) begin
      m[B_REGDST]   = 1'b0;
      m[B_MEMTOREG] = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign haz = i_valid & idex_p0[B_MEMREAD] & (idex_rt_p0 != '0) &
               ((idex_rt_p0 == i_rs) | (idex_rt_p0 == i_rt));

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_p0    <= '0;
      idex_rt_p0 <= '0;
      exmem_p1   <= '0;
      memwb_p2   <= '0;
      stall_cnt  <= '0;
    end else if (!i_hold) begin
      // MEM/WB always advances unless frozen, so a resolving branch still retires.
      memwb_p2 <= exmem_p1[1:0];
      if (i_flush) begin
        exmem_p1   <= '0;
        idex_p0    <= '0;
        idex_rt_p0 <= '0;
      end else if (haz) begin
        exmem_p1   <= idex_p0[4:0];
        idex_p0    <= '0;
        idex_rt_p0 <= '0;
        stall_cnt  <= sat_inc(stall_cnt);
      end else begin
        exmem_p1   <= idex_p0[4:0];
        idex_p0    <= mask_ctrl(i_ctrl, i_valid);
        idex_rt_p0 <= i_rt;
      end
    end
  end

  always_comb begin
    o_pc_write   = 1'b1;
    o_ifid_write = 1'b1;
    o_ifid_flush = 1'b0;
    if (rst) begin
      o_pc_write   = 1'b1;
      o_ifid_write = 1'b1;
    end else if (i_hold) begin
      o_pc_write   = 1'b0;
      o_ifid_write = 1'b0;
    end else if (i_flush) begin
      o_ifid_flush = 1'b1;
    end else if (haz) begin
      o_pc_write   = 1'b0;
      o_ifid_write = 1'b0;
    end
  end

  assign o_ex_ctrl   = idex_p0[8:5];
  assign o_ex_rt     = idex_rt_p0;
  assign o_mem_ctrl  = exmem_p1[4:2];
  assign o_wb_ctrl   = memwb_p2;
  assign o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed bench for ctrl_pipe_hazard; a second narrow-counter instance exercises saturation.
module tb_ctrl_pipe_hazard;

  logic        clk;
  logic        rst;
  logic [8:0]  i_ctrl;
  logic        i_valid;
  logic [4:0]  i_rs;
  logic [4:0]  i_rt;
  logic        i_flush;
  logic        i_hold;

  logic [3:0]  o_ex_ctrl;
  logic [4:0]  o_ex_rt;
  logic [2:0]  o_mem_ctrl;
  logic [1:0]  o_wb_ctrl;
  logic        o_pc_write;
  logic        o_ifid_write;
  logic        o_ifid_flush;
  logic [15:0] o_stall_cnt;

  logic [3:0]  s_ex_ctrl;
  logic [4:0]  s_ex_rt;
  logic [2:0]  s_mem_ctrl;
  logic [1:0]  s_wb_ctrl;
  logic        s_pc_write;
  logic        s_ifid_write;
  logic        s_ifid_flush;
  logic [3:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;

  ctrl_pipe_hazard u_dut (
    .clk(clk), .rst(rst), .i_ctrl(i_ctrl), .i_valid(i_valid), .i_rs(i_rs), .i_rt(i_rt),
    .i_flush(i_flush), .i_hold(i_hold), .o_ex_ctrl(o_ex_ctrl), .o_ex_rt(o_ex_rt),
    .o_mem_ctrl(o_mem_ctrl), .o_wb_ctrl(o_wb_ctrl), .o_pc_write(o_pc_write),
    .o_ifid_write(o_ifid_write), .o_ifid_flush(o_ifid_flush), .o_stall_cnt(o_stall_cnt)
  );

  ctrl_pipe_hazard #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .i_ctrl(i_ctrl), .i_valid(i_valid), .i_rs(i_rs), .i_rt(i_rt),
    .i_flush(i_flush), .i_hold(i_hold), .o_ex_ctrl(s_ex_ctrl), .o_ex_rt(s_ex_rt),
    .o_mem_ctrl(s_mem_ctrl), .o_wb_ctrl(s_wb_ctrl), .o_pc_write(s_pc_write),
    .o_ifid_write(s_ifid_write), .o_ifid_flush(s_ifid_flush), .o_stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [8:0] c, input logic v, input logic [4:0] rs,
                       input logic [4:0] rt);
    i_ctrl  = c;
    i_valid = v;
    i_rs    = rs;
    i_rt    = rt;
  endtask

  initial begin
    rst = 1'b1; i_flush = 1'b0; i_hold = 1'b0;
    drive(9'h000, 1'b0, 5'd0, 5'd0);
    tick; tick;
    rst = 1'b0;
    settle;
    chk("rst_ex",   32'(o_ex_ctrl),    32'h0);
    chk("rst_rt",   32'(o_ex_rt),      32'h0);
    chk("rst_mem",  32'(o_mem_ctrl),   32'h0);
    chk("rst_wb",   32'(o_wb_ctrl),    32'h0);
    chk("rst_cnt",  32'(o_stall_cnt),  32'h0);
    chk("rst_pcw",  32'(o_pc_write),   32'h1);
    chk("rst_ifw",  32'(o_ifid_write), 32'h1);
    chk("rst_iff",  32'(o_ifid_flush), 32'h0);
    chk("rst_sat",  32'({s_ex_ctrl, s_ex_rt, s_mem_ctrl, s_wb_ctrl, s_pc_write,
                         s_ifid_write, s_ifid_flush, s_stall_cnt}), 32'h60);

    // R-type flows through all three stages
    drive(9'h182, 1'b1, 5'd1, 5'd2);
    tick;
    chk("rtype_ex", 32'(o_ex_ctrl), 32'hC);
    chk("rtype_rt", 32'(o_ex_rt),   32'h2);
    drive(9'h000, 1'b0, 5'd0, 5'd0);
    tick;
    chk("rtype_mem", 32'(o_mem_ctrl), 32'h0);
    tick;
    chk("rtype_wb", 32'(o_wb_ctrl), 32'h2);

    // store with don't-care bits set
    drive(9'b1001_001_01, 1'b1, 5'd3, 5'd4);
    tick;
    chk("sw_ex", 32'(o_ex_ctrl), 32'h1);
    drive(9'h000, 1'b0, 5'd0, 5'd0);
    tick;
    chk("sw_mem", 32'(o_mem_ctrl), 32'h1);
    tick;
    chk("sw_wb", 32'(o_wb_ctrl), 32'h0);

    // load-use stall
    drive(9'h02B, 1'b1, 5'd1, 5'd5);
    tick;
    chk("lw_ex", 32'(o_ex_ctrl), 32'h1);
    chk("lw_rt", 32'(o_ex_rt),   32'h5);
    drive(9'h182, 1'b1, 5'd5, 5'd6);
    settle;
    chk("haz_pcw", 32'(o_pc_write),   32'h0);
    chk("haz_ifw", 32'(o_ifid_write), 32'h0);
    tick;
    chk("haz_ex",  32'(o_ex_ctrl),   32'h0);
    chk("haz_mem", 32'(o_mem_ctrl),  32'h2);
    chk("haz_cnt", 32'(o_stall_cnt), 32'h1);
    chk("haz_pcw_rel", 32'(o_pc_write), 32'h1);
    tick;
    chk("haz_add_ex", 32'(o_ex_ctrl), 32'hC);
    chk("haz_add_rt", 32'(o_ex_rt),   32'h6);
    chk("haz_lw_wb",  32'(o_wb_ctrl), 32'h3);

    // load into r0 never stalls
    drive(9'h02B, 1'b1, 5'd1, 5'd0);
    tick;
    drive(9'h182, 1'b1, 5'd0, 5'd0);
    settle;
    chk("r0_pcw", 32'(o_pc_write), 32'h1);
    tick;
    chk("r0_ex",  32'(o_ex_ctrl),   32'hC);
    chk("r0_cnt", 32'(o_stall_cnt), 32'h1);

    // back-to-back loads: one stall per dependent pair
    drive(9'h02B, 1'b1, 5'd1, 5'd5);
    tick;
    drive(9'h02B, 1'b1, 5'd5, 5'd7);
    settle;
    chk("b2b_pcw1", 32'(o_pc_write), 32'h0);
    tick;
    settle;
    chk("b2b_pcw_re", 32'(o_pc_write), 32'h1);
    tick;
    chk("b2b_lw2_rt", 32'(o_ex_rt), 32'h7);
    drive(9'h182, 1'b1, 5'd7, 5'd8);
    settle;
    chk("b2b_pcw2", 32'(o_pc_write), 32'h0);
    tick;
    chk("b2b_cnt", 32'(o_stall_cnt), 32'h3);
    tick;
    chk("b2b_add_ex", 32'(o_ex_ctrl), 32'hC);
    drive(9'h000, 1'b0, 5'd0, 5'd0);
    tick; tick; tick;

    // flush beats a simultaneous hazard
    drive(9'h192, 1'b1, 5'd1, 5'd2);
    tick;
    drive(9'h02B, 1'b1, 5'd1, 5'd5);
    tick;
    chk("fl_pre_mem", 32'(o_mem_ctrl), 32'h4);
    chk("fl_pre_ex",  32'(o_ex_ctrl),  32'h1);
    drive(9'h182, 1'b1, 5'd5, 5'd6);
    i_flush = 1'b1;
    settle;
    chk("fl_iff", 32'(o_ifid_flush), 32'h1);
    chk("fl_pcw", 32'(o_pc_write),   32'h1);
    chk("fl_ifw", 32'(o_ifid_write), 32'h1);
    tick;
    i_flush = 1'b0;
    drive(9'h000, 1'b0, 5'd0, 5'd0);
    settle;
    chk("fl_ex",  32'(o_ex_ctrl),   32'h0);
    chk("fl_mem", 32'(o_mem_ctrl),  32'h0);
    chk("fl_wb",  32'(o_wb_ctrl),   32'h2);
    chk("fl_cnt", 32'(o_stall_cnt), 32'h3);
    chk("fl_iff_off", 32'(o_ifid_flush), 32'h0);

    // hold during a hazard, then reset mid-stream
    drive(9'h192, 1'b1, 5'd1, 5'd2);
    tick;
    drive(9'h02B, 1'b1, 5'd1, 5'd5);
    tick;
    drive(9'h182, 1'b1, 5'd5, 5'd6);
    i_hold = 1'b1; i_flush = 1'b1;
    settle;
    chk("hold_pcw", 32'(o_pc_write),   32'h0);
    chk("hold_ifw", 32'(o_ifid_write), 32'h0);
    chk("hold_iff", 32'(o_ifid_flush), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("hold_ex",  32'(o_ex_ctrl),   32'h1);
      chk("hold_rt",  32'(o_ex_rt),     32'h5);
      chk("hold_mem", 32'(o_mem_ctrl),  32'h4);
      chk("hold_cnt", 32'(o_stall_cnt), 32'h3);
    end
    i_hold = 1'b0; i_flush = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    drive(9'h000, 1'b0, 5'd0, 5'd0);
    settle;
    chk("mrst_ex",  32'(o_ex_ctrl),    32'h0);
    chk("mrst_rt",  32'(o_ex_rt),      32'h0);
    chk("mrst_mem", 32'(o_mem_ctrl),   32'h0);
    chk("mrst_wb",  32'(o_wb_ctrl),    32'h0);
    chk("mrst_cnt", 32'(o_stall_cnt),  32'h0);
    chk("mrst_pcw", 32'(o_pc_write),   32'h1);
    chk("mrst_ifw", 32'(o_ifid_write), 32'h1);

    // endless self-dependent loads: one stall every two cycles
    drive(9'h02B, 1'b1, 5'd5, 5'd5);
    for (int k = 0; k < 40; k++) tick;
    chk("sat_main_cnt", 32'(o_stall_cnt), 32'h14);
    chk("sat_narrow_cnt", 32'(s_stall_cnt), 32'hF);
    drive(9'h000, 1'b0, 5'd0, 5'd0);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
